// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with ALU-control decode and EX operand issue.
// Operands are forwarded combinationally from EX/MEM and MEM/WB; a stall refreshes stored operands.
module id_ex_issue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         btnc_i,
    input  logic         id_valid_i,
    input  logic [1:0]   id_aluop_i,
    input  logic [5:0]   id_funct_i,
    input  logic [4:0]   id_rs_i,
    input  logic [4:0]   id_rt_i,
    input  logic [4:0]   id_rd_i,
    input  logic [W-1:0] id_rs_data_i,
    input  logic [W-1:0] id_rt_data_i,
    input  logic [W-1:0] id_imm_i,
    input  logic         id_alusrc_i,
    input  logic         id_regdst_i,
    input  logic         id_regwrite_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         exmem_regwrite_i,
    input  logic [4:0]   exmem_rd_i,
    input  logic [W-1:0] exmem_result_i,
    input  logic         memwb_regwrite_i,
    input  logic [4:0]   memwb_rd_i,
    input  logic [W-1:0] memwb_result_i,
    output logic [W-1:0] ALU1,
    output logic [W-1:0] ALU2,
    output logic [3:0]   ALU_control,
    output logic         ex_valid_o,
    output logic         ex_regwrite_o,
    output logic [4:0]   ex_wreg_o,
    output logic [W-1:0] ex_store_data_o,
    output logic         illegal_o
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;

    typedef struct packed {
        logic         valid;
        logic [3:0]   aluctl;
        logic         illegal;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   wreg;
        logic         regwrite;
        logic         alusrc;
        logic [W-1:0] rs_val;
        logic [W-1:0] rt_val;
        logic [W-1:0] imm;
    } entry_t;

    entry_t entry_q, entry_d, load_entry;
    logic [3:0]   dec_ctl;
    logic         dec_illegal;
    logic [W-1:0] rs_fwd, rt_fwd;

    function automatic entry_t bubble();
        entry_t b;
        b        = '0;
        b.aluctl = CTL_ADD;
        return b;
    endfunction

    // EX/MEM wins over MEM/WB; register 0 is never a forwarding target.
    function automatic logic [W-1:0] fwd(
        input logic [4:0]   r,
        input logic [W-1:0] stored,
        input logic         em_we,
        input logic [4:0]   em_rd,
        input logic [W-1:0] em_res,
        input logic         mw_we,
        input logic [4:0]   mw_rd,
        input logic [W-1:0] mw_res
    );
        if (em_we && em_rd != 5'd0 && em_rd == r)
            return em_res;
        else if (mw_we && mw_rd != 5'd0 && mw_rd == r)
            return mw_res;
        else
            return stored;
    endfunction

    always_comb begin
        dec_ctl     = CTL_ADD;
        dec_illegal = 1'b0;
        unique case (id_aluop_i)
            2'b00: dec_ctl = CTL_ADD;
            2'b01: dec_ctl = CTL_SUB;
            2'b11: dec_ctl = CTL_OR;
            default: begin
                case (id_funct_i)
                    6'b100000: dec_ctl = CTL_ADD;
                    6'b100010: dec_ctl = CTL_SUB;
                    6'b100100: dec_ctl = CTL_AND;
                    6'b100101: dec_ctl = CTL_OR;
                    6'b101010: dec_ctl = CTL_SLT;
                    default: begin
                        dec_ctl     = CTL_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        load_entry          = '0;
        load_entry.valid    = 1'b1;
        load_entry.aluctl   = dec_ctl;
        load_entry.illegal  = dec_illegal;
        load_entry.rs       = id_rs_i;
        load_entry.rt       = id_rt_i;
        load_entry.wreg     = id_regdst_i ? id_rd_i : id_rt_i;
        // An unsupported funct must never write the register file.
        load_entry.regwrite = id_regwrite_i & ~dec_illegal;
        load_entry.alusrc   = id_alusrc_i;
        load_entry.rs_val   = id_rs_data_i;
        load_entry.rt_val   = id_rt_data_i;
        load_entry.imm      = id_imm_i;
    end

    always_comb begin
        rs_fwd = fwd(entry_q.rs, entry_q.rs_val, exmem_regwrite_i, exmem_rd_i, exmem_result_i,
                     memwb_regwrite_i, memwb_rd_i, memwb_result_i);
        rt_fwd = fwd(entry_q.rt, entry_q.rt_val, exmem_regwrite_i, exmem_rd_i, exmem_result_i,
                     memwb_regwrite_i, memwb_rd_i, memwb_result_i);
    end

    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = bubble();
        end else if (stall_i) begin
            // Capture forwarded values so a producer retiring mid-stall is not lost.
            entry_d.rs_val = rs_fwd;
            entry_d.rt_val = rt_fwd;
        end else if (id_valid_i) begin
            entry_d = load_entry;
        end else begin
            entry_d = bubble();
        end
    end

    always_ff @(posedge clk or posedge btnc_i) begin
        if (btnc_i) entry_q <= bubble();
        else        entry_q <= entry_d;
    end

    assign ALU1            = rs_fwd;
    assign ALU2            = entry_q.alusrc ? entry_q.imm : rt_fwd;
    assign ex_store_data_o = rt_fwd;
    assign ALU_control     = entry_q.aluctl;
    assign ex_valid_o      = entry_q.valid;
    assign ex_regwrite_o   = entry_q.valid & entry_q.regwrite;
    assign ex_wreg_o       = entry_q.wreg;
    assign illegal_o       = entry_q.valid & entry_q.illegal;

endmodule
